// File: rtl/mul16_share_ctrl.sv
// mul16_share_ctrl: round-robin sharing of one multicycle combinational multiplier
// between two valid/ready requesters, returning id-tagged registered products.
module mul16_share_ctrl #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_prod,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [2*WIDTH-1:0] rsp_prod,
    output logic               busy
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       last_grant;
    logic       grant;
    logic       accept;

    generate
        if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
            $error("mul16_share_ctrl: SETTLE must be in 1..15");
        end
    endgenerate

    // On a tie the requester that did not win last time goes first.
    assign grant      = (req0_valid && req1_valid) ? !last_grant : req1_valid;
    assign req0_ready = (state == S_IDLE) && !grant && req0_valid;
    assign req1_ready = (state == S_IDLE) && grant && req1_valid;
    assign accept     = req0_ready || req1_ready;
    assign busy       = state != S_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            mul_a      <= '0;
            mul_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_prod   <= '0;
            cnt        <= '0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    mul_a      <= grant ? req1_a : req0_a;
                    mul_b      <= grant ? req1_b : req0_b;
                    rsp_id     <= grant;
                    last_grant <= grant;
                    cnt        <= 4'(SETTLE - 1);
                    state      <= S_SETTLE;
                end
                S_SETTLE: if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    rsp_prod  <= mul_prod;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul16_share_ctrl.sv
// tb_mul16_share_ctrl: scoreboard bench for the shared multiplier controller,
// with a behavioural multiplier and an independent arbitration model.
module tb_mul16_share_ctrl;
    localparam int W  = 16;
    localparam int ST = 3;

    logic           clk = 0, rst_n = 0;
    logic           req0_valid = 0, req1_valid = 0, rsp_ready = 1;
    logic [W-1:0]   req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic           req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [W-1:0]   mul_a, mul_b;
    logic [2*W-1:0] mul_prod, rsp_prod;

    mul16_share_ctrl #(.WIDTH(W), .SETTLE(ST)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_prod(mul_prod),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_prod(rsp_prod),
        .busy(busy)
    );

    assign mul_prod = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};

    always #5 clk = ~clk;

    typedef struct {logic id; logic [2*W-1:0] prod;} exp_t;
    exp_t sb[$];
    logic got_ids[$];
    int total = 0, bad = 0;
    int cyc = 0, acc_cyc = 0, acc_cnt = 0, hs_cnt = 0, last_acc = 0;
    logic prev_v = 0, m_last = 1, m_g, tput = 0, have_last = 0;
    exp_t e, r;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!rsp_valid && n < 60) begin
            tick;
            n++;
        end
        if (!rsp_valid) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || sb.size() != 0) && n < 100) begin
            tick;
            n++;
        end
        chk({tag, "_drain"}, {busy, 31'(sb.size())}, 0);
    endtask

    always @(posedge clk) cyc++;

    // Monitor: arbitration model, scoreboard push/pop, latency and throughput checks.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 0;
            m_last = 1;
        end else begin
            if (req0_ready && req1_ready) chk("both_ready", 1, 0);
            if (!busy && (req0_valid || req1_valid)) begin
                m_g = (req0_valid && req1_valid) ? !m_last : req1_valid;
                chk("grant", {req1_ready, req0_ready}, m_g ? 2'b10 : 2'b01);
                m_last = m_g;
                e.id = m_g;
                e.prod = m_g ? {{W{1'b0}}, req1_a} * {{W{1'b0}}, req1_b}
                             : {{W{1'b0}}, req0_a} * {{W{1'b0}}, req0_b};
                sb.push_back(e);
                if (tput && have_last) chk("tput", cyc - last_acc, ST + 2);
                have_last = tput;
                last_acc = cyc;
                acc_cyc = cyc;
                acc_cnt++;
            end
            if (rsp_valid && !prev_v) chk("latency", cyc - acc_cyc, ST + 1);
            prev_v = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                hs_cnt++;
                got_ids.push_back(rsp_id);
                if (sb.size() == 0) chk("spurious_rsp", 1, 0);
                else begin
                    r = sb.pop_front();
                    chk("rsp_id", rsp_id, r.id);
                    chk("rsp_prod", rsp_prod, r.prod);
                end
            end
        end
    end

    initial begin
        logic [2*W-1:0] hp;
        logic hi, seen;
        int base_h, base_a, n;
        repeat (3) tick;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_prod", rsp_prod, 0);
        chk("rst_id", rsp_id, 0);
        rst_n = 1;
        tick;

        // single op 3*5
        req0_a = 3; req0_b = 5; req0_valid = 1;
        tick;
        req0_valid = 0;
        wait_rsp("single");
        chk("single_prod", rsp_prod, 15);
        chk("single_id", rsp_id, 0);
        tick;
        wait_idle("single");

        // async reset in the middle of SETTLE drops the operation
        req0_a = 9; req0_b = 4; req0_valid = 1;
        tick;
        req0_valid = 0;
        #2;
        rst_n = 0;
        #1;
        chk("arst_valid", rsp_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_mul_a", mul_a, 0);
        sb.delete();
        tick;
        rst_n = 1;
        seen = 0;
        repeat (10) begin
            tick;
            if (rsp_valid) seen = 1;
        end
        chk("arst_no_rsp", seen, 0);

        // tie from reset: req0 first, then alternation
        rst_n = 0;
        req0_a = 7; req0_b = 9; req1_a = 100; req1_b = 200;
        req0_valid = 1; req1_valid = 1;
        got_ids.delete();
        tick;
        rst_n = 1;
        n = 0;
        while (hs_cnt < 4 && n < 200) begin
            tick;
            n++;
        end
        req0_valid = 0; req1_valid = 0;
        chk("tie_count", hs_cnt >= 4, 1);
        if (got_ids.size() >= 4)
            chk("tie_order", {got_ids[0], got_ids[1], got_ids[2], got_ids[3]}, 4'b0101);
        wait_idle("tie");

        // backpressure with max operands
        rsp_ready = 0;
        req0_a = 16'hFFFF; req0_b = 16'hFFFF; req0_valid = 1;
        tick;
        req0_valid = 0;
        req1_a = 5; req1_b = 6; req1_valid = 1;
        wait_rsp("bp");
        chk("max_prod", rsp_prod, 32'hFFFE0001);
        chk("max_id", rsp_id, 0);
        hp = rsp_prod; hi = rsp_id;
        repeat (10) begin
            tick;
            chk("bp_stable", {rsp_valid, rsp_id, rsp_prod}, {1'b1, hi, hp});
            chk("bp_ready", {req0_ready, req1_ready}, 0);
        end
        base_h = hs_cnt; base_a = acc_cnt;
        req1_valid = 0; rsp_ready = 1;
        repeat (6) tick;
        chk("bp_one_hs", hs_cnt - base_h, 1);
        chk("bp_dropped_req", acc_cnt - base_a, 0);
        chk("bp_idle", busy, 0);

        // zero times max
        req0_a = 0; req0_b = 16'hFFFF; req0_valid = 1;
        tick;
        req0_valid = 0;
        wait_rsp("zero");
        chk("zero_prod", rsp_prod, 0);
        tick;
        wait_idle("zero");

        // throughput with req1 held valid
        req1_a = 11; req1_b = 13;
        base_a = acc_cnt;
        tput = 1;
        req1_valid = 1;
        n = 0;
        while (acc_cnt - base_a < 6 && n < 100) begin
            tick;
            n++;
        end
        chk("tput_count", acc_cnt - base_a >= 6, 1);
        tput = 0;
        req1_valid = 0;
        wait_idle("tput");

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
